// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// The sub field exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   // Requester/consumer side
   modport master (
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   // Adder controller side
   modport slave (
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared 1-bit slice, LSB-first, one bit per clock.
// Optional subtract mode (A-B, cout = no-borrow) under `define SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_adder_ctrl_if.slave bus,
   output logic              busy
);
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             cout_q;
   logic             in_ready_q;
   logic             out_valid_q;

   // Shared 1-bit slice: two half-adder stages plus carry OR
   logic ha0_s, ha0_c, ha1_s, ha1_c;
   logic slice_s, slice_c;

   assign ha0_s   = a_sh[0] ^ b_sh[0];
   assign ha0_c   = a_sh[0] & b_sh[0];
   assign ha1_s   = ha0_s ^ carry;
   assign ha1_c   = ha0_s & carry;
   assign slice_s = ha1_s;
   assign slice_c = ha0_c | ha1_c;

   // Subtract is A + ~B + 1, so only the B image and the initial carry change
   logic [WIDTH-1:0] b_load;
   logic             c_init;
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load = bus.sub ? ~bus.b : bus.b;
   assign c_init = bus.sub;
`else
   assign b_load = bus.b;
   assign c_init = 1'b0;
`endif

   logic [WIDTH-1:0] res_next;
   assign res_next = {slice_s, res_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy        <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         cnt         <= '0;
         carry       <= 1'b0;
         a_sh        <= '0;
         b_sh        <= '0;
         res_sh      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh       <= bus.a;
                  b_sh       <= b_load;
                  carry      <= c_init;
                  cnt        <= '0;
                  in_ready_q <= 1'b0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               carry  <= slice_c;
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               res_sh <= res_next;
               cnt    <= cnt + CNT_W'(1);
               // Publish only the complete word so partial sums never leak out
               if (cnt == LAST_BIT) begin
                  sum_q       <= res_next;
                  cout_q      <= slice_c;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy        <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy        <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): arithmetic model plus directed vectors.
// Build with +define+SERIAL_ADDER_SUB_EN to also exercise subtract mode.
module tb_serial_adder_ctrl;
   localparam int unsigned WIDTH = 8;

   logic clk;
   logic rst;
   logic busy;

   serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   int checks = 0;
   int errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Model: result is plain (A+B) or (A-B) arithmetic, published WIDTH edges after accept
   int         m_state = 0;   // 0 waiting for operands, 1 computing, 2 holding result
   int         m_left  = 0;
   bit         m_live  = 1'b0;
   logic [7:0] m_sum, p_sum;
   logic       m_cout, p_cout;
   logic [8:0] m_r;

   always @(posedge clk) begin
      if (rst) begin
         m_state = 0;
         m_sum   = 8'h00;
         m_cout  = 1'b0;
         m_live  = 1'b1;
      end else if (m_live) begin
         case (m_state)
            0: if (bus.in_valid) begin
`ifdef SERIAL_ADDER_SUB_EN
                  if (bus.sub) m_r = {1'b0, bus.a} + {1'b0, ~bus.b} + 9'd1; else
`endif
                  m_r = {1'b0, bus.a} + {1'b0, bus.b};
                  p_sum   = m_r[7:0];
                  p_cout  = m_r[8];
                  m_left  = WIDTH;
                  m_state = 1;
               end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  m_sum   = p_sum;
                  m_cout  = p_cout;
                  m_state = 2;
               end
            end
            default: if (bus.out_ready) m_state = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready",  32'(bus.in_ready),  32'(m_state == 0));
         chk("out_valid", 32'(bus.out_valid), 32'(m_state == 2));
         chk("busy",      32'(busy),          32'(m_state != 0));
         chk("sum",       32'(bus.sum),       32'(m_sum));
         chk("cout",      32'(bus.cout),      32'(m_cout));
      end
   end

   task automatic run_op(input logic [7:0] a_i, input logic [7:0] b_i, input logic sub_i,
                         input logic [7:0] exp_s, input logic exp_c, input int stall,
                         input bit hold_valid, input string tag_i);
      string t;
      bit    seen;
      int    n;
      t = sub_i ? {tag_i, "-sub"} : tag_i;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a        = a_i;
      bus.b        = b_i;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub      = sub_i;
`endif
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            seen = 1'b1;
            break;
         end
      end
      chk({t, " accept"}, 32'(seen), 32'd1);
      @(posedge clk); #1;
      if (hold_valid) begin
         bus.a = 8'h11;
         bus.b = 8'h22;
      end else begin
         bus.in_valid = 1'b0;
      end
      seen = 1'b0;
      n    = 0;
      for (int i = 1; i <= 50; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            seen = 1'b1;
            n    = i;
            break;
         end
         if (hold_valid) chk({t, " in_ready in run"}, 32'(bus.in_ready), 32'd0);
      end
      chk({t, " done seen"}, 32'(seen), 32'd1);
      chk({t, " latency"}, 32'(n), 32'(WIDTH));
      bus.in_valid = 1'b0;
      chk({t, " sum"},       32'(bus.sum),  32'(exp_s));
      chk({t, " cout"},      32'(bus.cout), 32'(exp_c));
      chk({t, " model sum"}, 32'(m_sum),    32'(exp_s));
      chk({t, " model cout"},32'(m_cout),   32'(exp_c));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk({t, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
         chk({t, " stall sum"},       32'(bus.sum),       32'(exp_s));
         chk({t, " stall cout"},      32'(bus.cout),      32'(exp_c));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({t, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
      chk({t, " in_ready rise"},  32'(bus.in_ready),  32'd1);
      chk({t, " sum hold"},       32'(bus.sum),       32'(exp_s));
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = 8'h00;
      bus.b         = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub       = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset in_ready",  32'(bus.in_ready),  32'd1);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset busy",      32'(busy),          32'd0);
      chk("reset sum",       32'(bus.sum),       32'd0);
      chk("reset cout",      32'(bus.cout),      32'd0);

      run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, "t1 zero");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0, "t2 ripple");
      run_op(8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0, 0, 1'b1, "t3 held valid");
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1, 1'b0, "msb carry");
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, 1'b0, "to msb");
      run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 5, 1'b0, "t4 stall");

      // Abort in the fourth RUN cycle
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a        = 8'h33;
      bus.b        = 8'h44;
      @(negedge clk);
      chk("t5 accept ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t5 busy pre-rst", 32'(busy),    32'd1);
      chk("t5 sum pre-rst",  32'(bus.sum), 32'h4B);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5 in_ready",  32'(bus.in_ready),  32'd1);
      chk("t5 out_valid", 32'(bus.out_valid), 32'd0);
      chk("t5 busy",      32'(busy),          32'd0);
      chk("t5 sum",       32'(bus.sum),       32'd0);
      chk("t5 cout",      32'(bus.cout),      32'd0);
      run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0, 1'b0, "t5 after rst");

`ifdef SERIAL_ADDER_SUB_EN
      run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0, 1'b0, "t6 borrow");
      run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 0, 1'b0, "t6 no borrow");
      run_op(8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, 0, 1'b0, "t6 add mode");
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
